mode_record: RTL

// Record mode: captures notes the user plays on the note switches, measures how long

---
 rtl/mode_record.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mode_record.sv
// Record mode: samples the note switches, times each held note in TICK units and
// builds a song buffer in the same packed note/duration/octave format auto-play reads.
module mode_record #(
    parameter int SONG_TIME = 56,
    parameter int TICK      = 10000000,
    parameter int LEN_W     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rec_start,
    input  logic                     rec_stop,
    input  logic [3:0]               note_in,
    input  logic [1:0]               octave_in,
    output logic [SONG_TIME*4-1:0]   song_packed,
    output logic [SONG_TIME*4-1:0]   time_packed,
    output logic [SONG_TIME*2-1:0]   octave_packed,
    output logic [LEN_W-1:0]         rec_len,
    output logic                     recording,
    output logic                     rec_valid,
    output logic                     full,
    output logic [6:0]               led_out
);

    localparam int CYC_W = (TICK > 1) ? $clog2(TICK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;

    logic [3:0]               r_ns1, r_ns;
    logic [1:0]               r_os1, r_os;
    logic                     r_start_q, r_stop_q;
    logic [6:0]               r_led;

    logic [3:0]               r_cur_note;
    logic [1:0]               r_cur_oct;
    logic [CYC_W-1:0]         r_cyc;
    logic [3:0]               r_units;

    logic [SONG_TIME*4-1:0]   r_song;
    logic [SONG_TIME*4-1:0]   r_time;
    logic [SONG_TIME*2-1:0]   r_oct;
    logic [LEN_W-1:0]         r_rec_len;
    logic                     r_full;

    logic                     w_start_edge, w_stop_edge;
    logic                     w_tick, w_change;
    logic [3:0]               w_units_nx;
    logic [3:0]               w_note_clean;

    logic                     w_clear, w_latch, w_seg_wr, w_end_wr, w_full_set;
    logic [LEN_W-1:0]         w_end_idx, w_len_nx;

    assign w_note_clean = note_in[3] ? 4'd0 : note_in;
    assign w_start_edge = rec_start & ~r_start_q;
    assign w_stop_edge  = rec_stop & ~r_stop_q;
    assign w_tick       = (r_cyc == CYC_W'(TICK - 1));
    assign w_change     = (r_ns != r_cur_note) || (r_os != r_cur_oct);
    // Duration as it stands including this cycle, so a commit counts the current tick.
    assign w_units_nx   = (r_units == 4'd15) ? 4'd15 : r_units + {3'd0, w_tick};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_state_nx = r_state;
        w_clear    = 1'b0;
        w_latch    = 1'b0;
        w_seg_wr   = 1'b0;
        w_end_wr   = 1'b0;
        w_full_set = 1'b0;
        w_len_nx   = r_rec_len;
        w_end_idx  = r_rec_len;

        if (w_start_edge) begin
            w_clear    = 1'b1;
            w_len_nx   = '0;
            w_state_nx = S_ARMED;
        end else begin
            unique case (r_state)
                S_ARMED: begin
                    if (w_stop_edge) begin
                        w_end_wr   = 1'b1;
                        w_end_idx  = '0;
                        w_len_nx   = '0;
                        w_state_nx = S_DONE;
                    end else if (r_ns != 4'd0) begin
                        w_latch    = 1'b1;
                        w_state_nx = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_change || (w_units_nx == 4'd15) || w_stop_edge) begin
                        w_latch = 1'b1;
                        if (w_units_nx != 4'd0) begin
                            w_seg_wr = 1'b1;
                            w_len_nx = r_rec_len + LEN_W'(1);
                        end
                        if (w_len_nx == LEN_W'(SONG_TIME - 1)) begin
                            w_end_wr   = 1'b1;
                            w_end_idx  = LEN_W'(SONG_TIME - 1);
                            w_full_set = 1'b1;
                            w_state_nx = S_DONE;
                        end else if (w_stop_edge) begin
                            w_end_wr   = 1'b1;
                            w_end_idx  = w_len_nx;
                            w_state_nx = S_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizers, edge detectors and the LED echo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ns1     <= '0;
            r_ns      <= '0;
            r_os1     <= '0;
            r_os      <= '0;
            r_start_q <= 1'b0;
            r_stop_q  <= 1'b0;
            r_led     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so the 2-FF chain
            // really takes two edges regardless of statement order.
            r_ns1     <= w_note_clean;
            r_ns      <= r_ns1;
            r_os1     <= octave_in;
            r_os      <= r_os1;
            r_start_q <= rec_start;
            r_stop_q  <= rec_stop;
            r_led     <= (r_ns == 4'd0) ? 7'd0 : (7'd1 << (r_ns - 4'd1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_note <= '0;
            r_cur_oct  <= '0;
            r_cyc      <= '0;
            r_units    <= '0;
        end else if (w_latch) begin
            r_cur_note <= r_ns;
            r_cur_oct  <= r_os;
            r_cyc      <= '0;
            r_units    <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_cyc      <= w_tick ? '0 : r_cyc + CYC_W'(1);
            r_units    <= w_units_nx;
        end
    end

    // Song buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the buffer is reset because the outputs must read 0 during reset
            // and a fresh recording relies on slots past the end marker being 0.
            r_song    <= '0;
            r_time    <= '0;
            r_oct     <= '0;
            r_rec_len <= '0;
            r_full    <= 1'b0;
        end else if (w_clear) begin
            r_song    <= '0;
            r_time    <= '0;
            r_oct     <= '0;
            r_rec_len <= '0;
            r_full    <= 1'b0;
        end else begin
            r_rec_len <= w_len_nx;
            if (w_full_set) begin
                r_full <= 1'b1;
            end
            for (int i = 0; i < SONG_TIME; i++) begin
                if (w_seg_wr && (r_rec_len == LEN_W'(i))) begin
                    r_song[4*i +: 4] <= r_cur_note;
                    r_time[4*i +: 4] <= w_units_nx;
                    r_oct[2*i +: 2]  <= r_cur_oct;
                end
                if (w_end_wr && (w_end_idx == LEN_W'(i))) begin
                    r_song[4*i +: 4] <= 4'hF;
                    r_time[4*i +: 4] <= 4'h0;
                    r_oct[2*i +: 2]  <= 2'h0;
                end
            end
        end
    end

    assign song_packed   = r_song;
    assign time_packed   = r_time;
    assign octave_packed = r_oct;
    assign rec_len       = r_rec_len;
    assign full          = r_full;
    assign led_out       = r_led;
    assign recording     = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign rec_valid     = (r_state == S_DONE);

endmodule
